// File: rtl/wb_puls_multi.sv
// Wishbone slave for NCH debounced button inputs. Each input has its own edge-enable,
// pending, mask and debounce-counter state, and the block raises one level interrupt.
module wb_puls_multi #(
    parameter int NCH         = 8,
    parameter int CNT_W       = 20,
    parameter int DEB_DEFAULT = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    input  logic             wb_we_i,
    input  logic [3:0]       wb_sel_i,
    output logic             wb_ack_o,
    output logic             intr,
    input  logic [NCH-1:0]   puls_in,
    output logic [NCH-1:0]   puls_state
);
    localparam logic [CNT_W-1:0] DEB_RST = CNT_W'(DEB_DEFAULT);

    localparam logic [2:0] A_STATE = 3'd0;
    localparam logic [2:0] A_PEND  = 3'd1;
    localparam logic [2:0] A_MASK  = 3'd2;
    localparam logic [2:0] A_RISE  = 3'd3;
    localparam logic [2:0] A_FALL  = 3'd4;
    localparam logic [2:0] A_DEB   = 3'd5;

    logic [NCH-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NCH-1:0]   st_q, st_d;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [NCH-1:0]   pend_q, pend_d, mask_q, mask_d;
    logic [NCH-1:0]   rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [CNT_W-1:0] deb_q, deb_d;
    logic             ack_q, ack_d, intr_q, intr_d;
    logic [31:0]      dat_q, dat_d;

    logic             accept, wr;
    logic [2:0]       adr;
    logic [31:0]      byte_mask, rdata;
    logic [NCH-1:0]   edge_set, pend_clr;
    logic             unused_bits;

    assign adr         = wb_adr_i[4:2];
    assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i, byte_mask};

    always_comb begin
        accept    = wb_stb_i & wb_cyc_i & ~ack_q;
        wr        = accept & wb_we_i;
        byte_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
        sync1_d   = puls_in;
        sync2_d   = sync1_q;

        // A channel's counter runs only while the synchronised pin disagrees with the stable level.
        st_d = st_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != st_q[i]) begin
                if (cnt_q[i] < deb_q) cnt_d[i] = cnt_q[i] + CNT_W'(1);
                else                  st_d[i]  = sync2_q[i];
            end
        end

        edge_set = (st_d & ~st_q & rise_en_q) | (~st_d & st_q & fall_en_q);
        pend_clr = '0;
        if (wr && adr == A_PEND) pend_clr = wb_dat_i[NCH-1:0] & byte_mask[NCH-1:0];
        // A new edge beats a clear arriving in the same cycle.
        pend_d = (pend_q & ~pend_clr) | edge_set;

        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        deb_d     = deb_q;
        if (wr) begin
            case (adr)
                A_MASK: mask_d    = (mask_q & ~byte_mask[NCH-1:0]) | (wb_dat_i[NCH-1:0] & byte_mask[NCH-1:0]);
                A_RISE: rise_en_d = (rise_en_q & ~byte_mask[NCH-1:0]) | (wb_dat_i[NCH-1:0] & byte_mask[NCH-1:0]);
                A_FALL: fall_en_d = (fall_en_q & ~byte_mask[NCH-1:0]) | (wb_dat_i[NCH-1:0] & byte_mask[NCH-1:0]);
                A_DEB:  deb_d     = (deb_q & ~byte_mask[CNT_W-1:0]) | (wb_dat_i[CNT_W-1:0] & byte_mask[CNT_W-1:0]);
                default: ;
            endcase
        end

        rdata = '0;
        case (adr)
            A_STATE: rdata[NCH-1:0]   = st_q;
            A_PEND:  rdata[NCH-1:0]   = pend_q;
            A_MASK:  rdata[NCH-1:0]   = mask_q;
            A_RISE:  rdata[NCH-1:0]   = rise_en_q;
            A_FALL:  rdata[NCH-1:0]   = fall_en_q;
            A_DEB:   rdata[CNT_W-1:0] = deb_q;
            default: ;
        endcase

        ack_d  = accept;
        dat_d  = (accept && !wb_we_i) ? rdata : '0;
        intr_d = |(pend_q & mask_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            st_q      <= '0;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            rise_en_q <= '1;
            fall_en_q <= '0;
            deb_q     <= DEB_RST;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            intr_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            st_q      <= st_d;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            deb_q     <= deb_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            intr_q    <= intr_d;
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign intr       = intr_q;
    assign puls_state = st_q;
endmodule
